// File: rtl/btb_update_ctrl.sv
// EX-stage BTB/RAS update controller: detects mispredicts, emits a one-cycle redirect,
// and replays queued predictor-update records onto the operate_* port one per cycle.
module btb_update_ctrl #(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned ADD_GAP = 1,
    parameter int unsigned INDEX_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               br_valid,
    output logic               br_ready,
    input  logic [31:0]        br_pc,
    input  logic               br_is_branch,
    input  logic               br_is_call,
    input  logic               br_is_ret,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               pred_en,
    input  logic               pred_taken,
    input  logic [31:0]        pred_target,
    input  logic [INDEX_W-1:0] pred_index,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               operate_en,
    output logic [31:0]        operate_pc,
    output logic [INDEX_W-1:0] operate_index,
    output logic               push_ras,
    output logic               pop_ras,
    output logic               add_entry,
    output logic               delete_entry,
    output logic               pre_error,
    output logic               pre_right,
    output logic               target_error,
    output logic               right_orien,
    output logic [31:0]        right_target
);
    localparam int unsigned AW = $clog2(QDEPTH);

    typedef struct packed {
        logic [31:0]        pc;
        logic [INDEX_W-1:0] index;
        logic               push_ras;
        logic               pop_ras;
        logic               add_entry;
        logic               delete_entry;
        logic               pre_error;
        logic               pre_right;
        logic               target_error;
        logic               right_orien;
        logic [31:0]        right_target;
    } rec_t;

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rec_t        mem [QDEPTH];
    rec_t        head;
    rec_t        new_rec;
    rec_t        op_rec;
    logic        has_rec;
    logic        full;
    logic        empty;
    logic        accept;
    logic        enq;
    logic        deq;
    logic [31:0] pc_plus4;
    logic [31:0] pnext;
    logic [31:0] anext;

    assign pc_plus4 = br_pc + 32'd4;
    assign pnext    = (pred_en && pred_taken) ? pred_target : pc_plus4;
    assign anext    = (br_is_branch && br_taken) ? br_target : pc_plus4;

    // First matching row wins; the shared fields are filled before the row-specific flags.
    always_comb begin
        new_rec              = '0;
        new_rec.pc           = br_pc;
        new_rec.index        = pred_index;
        new_rec.right_orien  = br_taken;
        new_rec.right_target = br_target;
        has_rec              = 1'b1;
        if (!br_is_branch) begin
            new_rec.delete_entry = 1'b1;
            has_rec              = pred_en;
        end else if (br_is_ret) begin
            new_rec.pop_ras   = 1'b1;
            new_rec.add_entry = !pred_en;
        end else if (!pred_en) begin
            new_rec.add_entry = 1'b1;
            new_rec.push_ras  = br_is_call;
            has_rec           = br_taken;
        end else begin
            new_rec.push_ras = br_is_call;
            if (pred_taken && br_taken && (pred_target != br_target))
                new_rec.target_error = 1'b1;
            else if (pred_taken == br_taken)
                new_rec.pre_right = 1'b1;
            else
                new_rec.pre_error = 1'b1;
        end
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign br_ready = resetn && !full;
    assign accept   = br_valid && br_ready;
    assign enq      = accept && has_rec;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (!empty && head.add_entry && (ADD_GAP != 0)) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = 3'(ADD_GAP);
                end
            end
            S_GAP: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        deq = (state == S_IDLE) && !empty;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            operate_en     <= 1'b0;
            op_rec         <= '0;
        end else begin
            redirect_valid <= accept && (pnext != anext);
            if (accept)
                redirect_pc <= anext;
            operate_en <= deq;
            if (deq)
                op_rec <= head;
        end
    end

    assign operate_pc    = op_rec.pc;
    assign operate_index = op_rec.index;
    assign push_ras      = op_rec.push_ras;
    assign pop_ras       = op_rec.pop_ras;
    assign add_entry     = op_rec.add_entry;
    assign delete_entry  = op_rec.delete_entry;
    assign pre_error     = op_rec.pre_error;
    assign pre_right     = op_rec.pre_right;
    assign target_error  = op_rec.target_error;
    assign right_orien   = op_rec.right_orien;
    assign right_target  = op_rec.right_target;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected redirects/records queued at drive time,
// popped and compared by a negedge monitor.
module tb_btb_update_ctrl;
    localparam int unsigned QDEPTH  = 4;
    localparam int unsigned ADD_GAP = 2;
    localparam int unsigned INDEX_W = 5;

    logic               clk = 1'b0;
    logic               resetn;
    logic               br_valid;
    logic               br_ready;
    logic [31:0]        br_pc;
    logic               br_is_branch;
    logic               br_is_call;
    logic               br_is_ret;
    logic               br_taken;
    logic [31:0]        br_target;
    logic               pred_en;
    logic               pred_taken;
    logic [31:0]        pred_target;
    logic [INDEX_W-1:0] pred_index;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               operate_en;
    logic [31:0]        operate_pc;
    logic [INDEX_W-1:0] operate_index;
    logic               push_ras;
    logic               pop_ras;
    logic               add_entry;
    logic               delete_entry;
    logic               pre_error;
    logic               pre_right;
    logic               target_error;
    logic               right_orien;
    logic [31:0]        right_target;

    always #5 clk = ~clk;

    btb_update_ctrl #(
        .QDEPTH (QDEPTH),
        .ADD_GAP(ADD_GAP),
        .INDEX_W(INDEX_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_pc         (br_pc),
        .br_is_branch  (br_is_branch),
        .br_is_call    (br_is_call),
        .br_is_ret     (br_is_ret),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .pred_en       (pred_en),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_index    (pred_index),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .operate_en    (operate_en),
        .operate_pc    (operate_pc),
        .operate_index (operate_index),
        .push_ras      (push_ras),
        .pop_ras       (pop_ras),
        .add_entry     (add_entry),
        .delete_entry  (delete_entry),
        .pre_error     (pre_error),
        .pre_right     (pre_right),
        .target_error  (target_error),
        .right_orien   (right_orien),
        .right_target  (right_target)
    );

    // flags order: push, pop, add, delete, pre_error, pre_right, target_error, right_orien
    typedef struct {
        logic [31:0]        pc;
        logic [INDEX_W-1:0] idx;
        bit                 chk_idx;
        logic [7:0]         flags;
        logic [31:0]        rt;
        int                 cyc;
    } exp_rec_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_rd_t;

    exp_rec_t rec_q[$];
    exp_rd_t  rd_q[$];
    int       strobe_log[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    exp_rec_t mr;
    exp_rd_t  md;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (redirect_valid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_redirect", 64'(redirect_valid), 64'd0);
                end else begin
                    md = rd_q.pop_front();
                    check("redirect_pc", 64'(redirect_pc), 64'(md.pc));
                    check("redirect_cycle", 64'(cyc), 64'(md.cyc));
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                check("redirect_missing", 64'(redirect_valid), 64'd1);
                void'(rd_q.pop_front());
            end

            if (operate_en) begin
                strobe_log.push_back(cyc);
                if (rec_q.size() == 0) begin
                    check("unexpected_operate", 64'(operate_en), 64'd0);
                end else begin
                    mr = rec_q.pop_front();
                    check("operate_pc", 64'(operate_pc), 64'(mr.pc));
                    check("operate_flags",
                          64'({push_ras, pop_ras, add_entry, delete_entry,
                               pre_error, pre_right, target_error, right_orien}),
                          64'(mr.flags));
                    check("right_target", 64'(right_target), 64'(mr.rt));
                    if (mr.chk_idx)
                        check("operate_index", 64'(operate_index), 64'(mr.idx));
                    if (mr.cyc >= 0)
                        check("operate_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end else if (rec_q.size() > 0 && rec_q[0].cyc >= 0 && rec_q[0].cyc <= cyc) begin
                check("operate_missing", 64'(operate_en), 64'd1);
                void'(rec_q.pop_front());
            end
        end
    end

    // Drives one resolved instruction, holds it until accepted, and queues the expected results.
    task automatic send(input logic [31:0] pc, input logic isb, input logic call, input logic ret,
                        input logic tk, input logic [31:0] tgt, input logic pen, input logic ptk,
                        input logic [31:0] ptgt, input logic [INDEX_W-1:0] pidx, input bit exact);
        logic [31:0] pnext;
        logic [31:0] anext;
        exp_rec_t    r;
        exp_rd_t     d;
        bit          has;
        bit          ok;
        logic        f_push, f_pop, f_add, f_del, f_perr, f_pright, f_terr;
        br_valid     = 1'b1;
        br_pc        = pc;
        br_is_branch = isb;
        br_is_call   = call;
        br_is_ret    = ret;
        br_taken     = tk;
        br_target    = tgt;
        pred_en      = pen;
        pred_taken   = ptk;
        pred_target  = ptgt;
        pred_index   = pidx;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (br_ready === 1'b1) begin
                ok    = 1'b1;
                pnext = (pen && ptk) ? ptgt : pc + 32'd4;
                anext = (isb && tk) ? tgt : pc + 32'd4;
                if (pnext != anext) begin
                    d.pc  = anext;
                    d.cyc = cyc + 1;
                    rd_q.push_back(d);
                end
                has = 1'b1;
                r.chk_idx = 1'b1;
                {f_push, f_pop, f_add, f_del, f_perr, f_pright, f_terr} = '0;
                if (!isb) begin
                    has   = pen;
                    f_del = 1'b1;
                end else if (ret) begin
                    f_pop = 1'b1;
                    f_add = !pen;
                end else if (!pen) begin
                    has       = tk;
                    f_add     = 1'b1;
                    f_push    = call;
                    r.chk_idx = 1'b0;
                end else begin
                    f_push = call;
                    if (ptk && tk && ptgt != tgt) f_terr = 1'b1;
                    else if (ptk == tk)           f_pright = 1'b1;
                    else                          f_perr = 1'b1;
                end
                if (has) begin
                    r.pc    = pc;
                    r.idx   = pidx;
                    r.flags = {f_push, f_pop, f_add, f_del, f_perr, f_pright, f_terr, tk};
                    r.rt    = tgt;
                    r.cyc   = exact ? cyc + 2 : -1;
                    rec_q.push_back(r);
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (ok) break;
        end
        br_valid = 1'b0;
        check("accepted", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; br_valid = 1'b0; br_pc = '0; br_is_branch = 1'b0; br_is_call = 1'b0;
        br_is_ret = 1'b0; br_taken = 1'b0; br_target = '0; pred_en = 1'b0; pred_taken = 1'b0;
        pred_target = '0; pred_index = '0;
        idle(2);
        check("rst_ready", 64'(br_ready), 64'd0);
        check("rst_redirect", 64'({redirect_valid, redirect_pc}), 64'd0);
        check("rst_operate", 64'({operate_en, operate_pc}), 64'd0);
        check("rst_fields", 64'({push_ras, pop_ras, add_entry, delete_entry, pre_error,
                                 pre_right, target_error, right_orien, operate_index}), 64'd0);
        resetn = 1'b1;
        #1;
        check("ready_after_rst", 64'(br_ready), 64'd1);
        idle(2);

        // directed single transactions, each drained before the next
        send(32'h1c000010, 1, 0, 0, 1, 32'h1c000040, 0, 0, 32'h0, 5'd0, 1); idle(6);
        send(32'h1c000010, 1, 0, 0, 0, 32'h1c000040, 1, 1, 32'h1c000040, 5'd7, 1); idle(6);
        send(32'h1c000030, 1, 0, 0, 1, 32'h1c000200, 1, 1, 32'h1c000100, 5'd3, 1); idle(6);
        send(32'h1c000020, 1, 1, 0, 1, 32'h1c000400, 0, 0, 32'h0, 5'd0, 1); idle(6);
        send(32'h1c000400, 1, 0, 1, 1, 32'h1c000024, 1, 1, 32'h1c000024, 5'd9, 1); idle(6);
        send(32'h1c000050, 1, 1, 0, 1, 32'h1c000800, 1, 1, 32'h1c000800, 5'd12, 1); idle(6);
        send(32'h1c000060, 1, 0, 0, 0, 32'h1c000900, 1, 0, 32'h1c000900, 5'd31, 1); idle(6);
        send(32'h1c000070, 1, 0, 0, 1, 32'h1c000a00, 1, 0, 32'h0, 5'd1, 1); idle(6);
        send(32'hfffffffc, 0, 0, 0, 0, 32'h0, 1, 1, 32'h1c001000, 5'd5, 1); idle(6);
        send(32'h1c000080, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 5'd0, 1); idle(6);
        send(32'h1c000090, 1, 0, 1, 1, 32'h1c000300, 0, 0, 32'h0, 5'd2, 1); idle(6);
        send(32'h1c0000a0, 1, 0, 0, 0, 32'h1c000b00, 0, 0, 32'h0, 5'd0, 1); idle(6);
        check("directed_drained", 64'(rec_q.size() + rd_q.size()), 64'd0);

        // back-to-back add records: queue fills, strobes spaced by the add gap
        strobe_log.delete();
        for (int unsigned i = 0; i < 6; i++)
            send(32'h1c001000 + 32'(i * 16), 1, 0, 0, 1, 32'h1c002000 + 32'(i * 16), 0, 0, 32'h0, 5'd0, 0);
        check("ready_low_full", 64'(br_ready), 64'd0);
        idle(30);
        check("burst_drained", 64'(rec_q.size()), 64'd0);
        check("burst_strobes", 64'(strobe_log.size()), 64'd6);
        for (int unsigned i = 1; i < 6; i++)
            if (i < strobe_log.size())
                check("burst_spacing", 64'(strobe_log[i] - strobe_log[i-1]), 64'(ADD_GAP + 1));

        // reset with records still pending
        for (int unsigned i = 0; i < 5; i++)
            send(32'h1c003000 + 32'(i * 16), 1, 0, 0, 1, 32'h1c004000 + 32'(i * 16), 0, 0, 32'h0, 5'd0, 0);
        idle(1);
        resetn = 1'b0;
        idle(1);
        check("mid_rst_ready", 64'(br_ready), 64'd0);
        check("mid_rst_redirect", 64'(redirect_valid), 64'd0);
        check("mid_rst_operate", 64'(operate_en), 64'd0);
        check("mid_rst_fields", 64'({operate_pc, push_ras, pop_ras, add_entry, right_orien}), 64'd0);
        rec_q.delete();
        strobe_log.delete();
        resetn = 1'b1;
        #1;
        check("ready_after_mid_rst", 64'(br_ready), 64'd1);
        check("no_redirect_after_rst", 64'(redirect_valid), 64'd0);
        idle(20);
        check("no_strobe_after_rst", 64'(strobe_log.size()), 64'd0);
        check("final_redirect_q", 64'(rd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
